fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader_if.sv | 30 +++
 rtl/fifo_reader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fifo_reader_if.sv
// Bundle of the burst-control, FIFO-side and downstream handshake signals of fifo_reader.
// The slave modport is the reader itself; the master modport is whoever drives it
// (controller, FIFO and downstream consumer combined).
interface fifo_reader_if #(
    parameter int WIDTH = 32,
    parameter int LENW  = 4
);
    logic             start;
    logic [LENW-1:0]  burst_len;
    logic             abort;
    logic             empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             rn;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             done;
    logic [LENW-1:0]  word_count;

    modport master (
        output start, burst_len, abort, empty, fifo_dout, dout_ready,
        input  rn, dout, dout_valid, busy, done, word_count
    );

    modport slave (
        input  start, burst_len, abort, empty, fifo_dout, dout_ready,
        output rn, dout, dout_valid, busy, done, word_count
    );
endinterface

// File: rtl/fifo_reader.sv
// Burst reader: pops burst_len words from a synchronous FIFO one at a time and
// presents each on a registered valid/ready output, counting delivered words.
module fifo_reader #(
    parameter int WIDTH = 32,
    parameter int LENW  = 4
) (
    input  logic          clock,
    input  logic          reset,
    fifo_reader_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPT,
        OUT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] dout_r;
    logic             dout_valid_r;
    logic [LENW-1:0]  word_count_r;
    logic [LENW-1:0]  len_r;
    logic [LENW-1:0]  wc_inc;

    logic             rn_c;
    logic             accept;
    logic             capture;
    logic             handshake;
    logic             drop_valid;
    logic             hs;

    assign wc_inc = word_count_r + LENW'(1);
    assign hs     = dout_valid_r && bus.dout_ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-edge datapath strobes
    always_comb begin
        state_nxt  = state;
        rn_c       = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        handshake  = 1'b0;
        drop_valid = 1'b0;
        case (state)
            IDLE: begin
                // abort alongside start suppresses the start
                if (bus.start && !bus.abort) begin
                    accept    = 1'b1;
                    state_nxt = (bus.burst_len != '0) ? REQ : DONE;
                end
            end
            REQ: begin
                // the pop still happens on an abort edge; the word is simply never captured
                rn_c = !bus.empty;
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (!bus.empty) begin
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else begin
                    capture   = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                // a handshake on the abort edge is still counted
                handshake = hs;
                if (bus.abort) begin
                    drop_valid = 1'b1;
                    state_nxt  = IDLE;
                end else if (hs) begin
                    state_nxt = (wc_inc == len_r) ? DONE : REQ;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output word, valid flag, delivered-word counter and latched burst length
    always_ff @(posedge clock) begin
        if (reset) begin
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            word_count_r <= '0;
            len_r        <= '0;
        end else begin
            if (accept) begin
                len_r        <= bus.burst_len;
                word_count_r <= '0;
            end
            if (capture) begin
                dout_r       <= bus.fifo_dout;
                dout_valid_r <= 1'b1;
            end
            if (handshake) begin
                word_count_r <= wc_inc;
                dout_valid_r <= 1'b0;
            end
            if (drop_valid) begin
                dout_valid_r <= 1'b0;
            end
        end
    end

    assign bus.rn         = rn_c;
    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.word_count = word_count_r;

endmodule
